// File: rtl/hbe200_pkg.sv
// rtl/hbe200_pkg.sv - shared constants, UART state type and baud helper for the HBE200 board top
package hbe200_pkg;

  localparam int BANNER_LEN = 8;

  // "HBE200\r\n", index 0 is sent first
  localparam logic [0:BANNER_LEN-1][7:0] BANNER = {
    8'h48, 8'h42, 8'h45, 8'h32, 8'h30, 8'h30, 8'h0D, 8'h0A
  };

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  function automatic int calc_baud_div(input int clk_hz, input int baud);
    int div;
    div = clk_hz / baud;
    return (div < 4) ? 4 : div;
  endfunction

endpackage

// File: rtl/hbe200_uart_rx.sv
// rtl/hbe200_uart_rx.sv - 8N1 UART receiver with input synchronizer, centre sampling and valid/ferr pulses
module hbe200_uart_rx
  import hbe200_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);

  logic [1:0]  sync_q;
  logic        rx_s;
  logic        rx_prev_q;
  uart_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;

  assign rx_s    = sync_q[1];
  assign rx_data = sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= UART_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = UART_START;
          cnt_d   = '0;
        end
      end
      UART_START: begin
        // mid start bit: a line back high means the edge was noise
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? UART_IDLE : UART_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UART_DATA: begin
        if (cnt_q == CW'(BAUD_DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = UART_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UART_STOP: begin
        if (cnt_q == CW'(BAUD_DIV - 1)) begin
          cnt_d    = '0;
          state_d  = UART_IDLE;
          rx_valid = rx_s;
          rx_ferr  = !rx_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/hbe200_board_top.sv
// rtl/hbe200_board_top.sv - HBE200 board top: reset sync, heartbeat, UART banner/echo and status LEDs
module hbe200_board_top
  import hbe200_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int HB_DIV = 50_000_000
) (
  input  logic CLK100MHZ,
  input  logic fpga_rst,
  input  logic mcu_rst,
  output logic led8,
  output logic led9,
  output logic led10,
  input  logic uart0_rxd,
  output logic uart0_txd
);

  localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int HB_W     = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

  logic clk;
  logic rst_in_n;
  logic [1:0] rst_sync_q;
  logic rst_n;

  assign clk      = CLK100MHZ;
  assign rst_in_n = fpga_rst & mcu_rst;
  assign rst_n    = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  logic [HB_W-1:0] hb_cnt_q;
  logic            hb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (hb_cnt_q == HB_W'(HB_DIV - 1)) begin
      hb_cnt_q <= '0;
      hb_q     <= ~hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q + HB_W'(1);
    end
  end

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  hbe200_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (uart0_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  uart_state_t   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_line;
  logic          tx_load_banner;
  logic          tx_load_echo;
  logic [3:0]    banner_idx_q;
  logic          banner_done;
  logic          echo_full_q;
  logic [7:0]    echo_data_q;
  logic          overrun;

  assign banner_done = (banner_idx_q == 4'(BANNER_LEN));
  assign overrun     = rx_valid && echo_full_q && !tx_load_echo;
  // held idle while in reset so the pin releases asynchronously
  assign uart0_txd   = rst_n ? tx_line : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= UART_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  // the IDLE cycle that picks up a byte is already the first start-bit cycle
  always_comb begin
    tx_state_d     = tx_state_q;
    tx_cnt_d       = tx_cnt_q;
    tx_bit_d       = tx_bit_q;
    tx_sh_d        = tx_sh_q;
    tx_load_banner = 1'b0;
    tx_load_echo   = 1'b0;
    tx_line        = 1'b1;
    case (tx_state_q)
      UART_IDLE: begin
        if (!banner_done)     tx_load_banner = 1'b1;
        else if (echo_full_q) tx_load_echo   = 1'b1;
        if (tx_load_banner || tx_load_echo) begin
          tx_line    = 1'b0;
          tx_sh_d    = tx_load_banner ? BANNER[banner_idx_q[2:0]] : echo_data_q;
          tx_cnt_d   = CW'(1);
          tx_state_d = UART_START;
        end
      end
      UART_START: begin
        tx_line = 1'b0;
        if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = UART_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      UART_DATA: begin
        tx_line = tx_sh_q[0];
        if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = UART_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      UART_STOP: begin
        tx_line = 1'b1;
        if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
          tx_cnt_d   = '0;
          tx_state_d = UART_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) banner_idx_q <= '0;
    else if (tx_load_banner) banner_idx_q <= banner_idx_q + 4'd1;
  end

  // a byte landing in the same cycle the TX takes the old one refills the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_full_q <= 1'b0;
      echo_data_q <= '0;
    end else if (rx_valid && (!echo_full_q || tx_load_echo)) begin
      echo_full_q <= 1'b1;
      echo_data_q <= rx_data;
    end else if (tx_load_echo) begin
      echo_full_q <= 1'b0;
    end
  end

  logic led9_q;
  logic led10_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led9_q  <= 1'b0;
      led10_q <= 1'b0;
    end else begin
      if (rx_valid)           led9_q  <= ~led9_q;
      if (rx_ferr || overrun) led10_q <= 1'b1;
    end
  end

  assign led8  = hb_q;
  assign led9  = led9_q;
  assign led10 = led10_q;

endmodule

// File: tb/tb_hbe200_board_top.sv
// tb/tb_hbe200_board_top.sv - directed self-checking bench for hbe200_board_top
`timescale 1ns/1ps
module tb_hbe200_board_top;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic fpga_rst;
  logic mcu_rst;
  logic uart0_rxd;
  logic led8;
  logic led9;
  logic led10;
  logic uart0_txd;

  int checks = 0;
  int errors = 0;

  logic [7:0] banner_exp [0:7] = '{8'h48, 8'h42, 8'h45, 8'h32, 8'h30, 8'h30, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  hbe200_board_top #(
    .CLK_HZ (1_843_200),
    .BAUD   (115200),
    .HB_DIV (16)
  ) dut (
    .CLK100MHZ (clk),
    .fpga_rst  (fpga_rst),
    .mcu_rst   (mcu_rst),
    .led8      (led8),
    .led9      (led9),
    .led10     (led10),
    .uart0_rxd (uart0_rxd),
    .uart0_txd (uart0_txd)
  );

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart0_rxd = fr[i];
      repeat (BD) @(negedge clk);
    end
    uart0_rxd = 1'b1;
  endtask

  // entered on the negedge of the first start-bit cycle; leaves one frame later
  task automatic uart_recv(output logic [7:0] b, output logic ok);
    ok = 1'b1;
    b  = 8'h00;
    repeat (BD / 2) @(negedge clk);
    if (uart0_txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = uart0_txd;
    end
    repeat (BD) @(negedge clk);
    if (uart0_txd !== 1'b1) ok = 1'b0;
    repeat (BD / 2) @(negedge clk);
  endtask

  task automatic wait_txd_low(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (uart0_txd === 1'b0) seen = 1'b1;
    end
  endtask

  task automatic watch_idle(input int n, output logic ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart0_txd !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    fpga_rst  = 1'b0;
    mcu_rst   = 1'b0;
    uart0_rxd = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if ({uart0_txd, led8, led9, led10} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: txd,led8,led9,led10=%b want 1000", i, {uart0_txd, led8, led9, led10});
      end
    end
  endtask

  task automatic test_banner();
    logic [7:0] b;
    logic ok;
    fpga_rst = 1'b1;
    mcu_rst  = 1'b1;
    @(negedge clk);
    checks++;
    if (uart0_txd !== 1'b1) begin errors++; $display("FAIL txd_early: txd=%b want 1", uart0_txd); end
    @(negedge clk);
    checks++;
    if (uart0_txd !== 1'b0) begin errors++; $display("FAIL txd_start_latency: txd=%b want 0", uart0_txd); end
    for (int i = 0; i < 8; i++) begin
      uart_recv(b, ok);
      checks++;
      if ({ok, b} !== {1'b1, banner_exp[i]}) begin
        errors++;
        $display("FAIL banner_byte %0d: got %h framing_ok=%b want %h", i, b, ok, banner_exp[i]);
      end
      if (i < 7) begin
        checks++;
        if (uart0_txd !== 1'b0) begin errors++; $display("FAIL banner_back_to_back %0d: txd=%b want 0", i, uart0_txd); end
      end
    end
    watch_idle(200, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL banner_once: txd left idle after banner, want steady 1"); end
  endtask

  task automatic test_heartbeat();
    logic ok;
    @(negedge clk);
    fpga_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (led8 !== 1'b0) begin errors++; $display("FAIL hb_reset: led8=%b want 0", led8); end
    fpga_rst = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 17 || k == 18 || k == 33 || k == 34) begin
        checks++;
        if (led8 !== ((k == 18 || k == 33) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL heartbeat cycle %0d: led8=%b want %b", k, led8, (k == 18 || k == 33));
        end
      end
    end
    repeat (8 * 10 * BD + 40) @(negedge clk);
    watch_idle(20, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL hb_banner_done: txd not idle after banner"); end
  endtask

  task automatic test_echo();
    logic [7:0] b;
    logic ok;
    logic seen;
    checks++;
    if (led9 !== 1'b0) begin errors++; $display("FAIL echo_led9_before: led9=%b want 0", led9); end
    fork
      uart_send(8'h55, 1'b1);
      begin
        wait_txd_low(400, seen);
        if (seen) uart_recv(b, ok);
      end
    join
    checks++;
    if (!seen || ok !== 1'b1 || b !== 8'h55) begin
      errors++;
      $display("FAIL echo_55: seen=%b got %h framing_ok=%b want 55", seen, b, ok);
    end
    checks++;
    if ({led9, led10} !== 2'b10) begin errors++; $display("FAIL echo_leds: led9,led10=%b want 10", {led9, led10}); end
  endtask

  task automatic test_ferr();
    logic ok;
    uart_send(8'hA3, 1'b0);
    watch_idle(64, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ferr_no_echo: txd activity after framing error, want none"); end
    checks++;
    if ({led9, led10} !== 2'b11) begin errors++; $display("FAIL ferr_leds: led9,led10=%b want 11", {led9, led10}); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic ok;
    logic seen;
    @(negedge clk);
    mcu_rst = 1'b0;
    repeat (2) @(negedge clk);
    mcu_rst = 1'b1;
    wait_txd_low(8, seen);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL mid_banner_start: seen=%b want 1", seen); end
    for (int i = 0; i < 3; i++) begin
      uart_recv(b, ok);
      checks++;
      if ({ok, b} !== {1'b1, banner_exp[i]}) begin
        errors++;
        $display("FAIL mid_banner_byte %0d: got %h framing_ok=%b want %h", i, b, ok, banner_exp[i]);
      end
    end
    repeat (24) @(negedge clk);
    checks++;
    if (uart0_txd !== 1'b0) begin errors++; $display("FAIL mid_byte3_bit0: txd=%b want 0", uart0_txd); end
    mcu_rst = 1'b0;
    #1;
    checks++;
    if ({uart0_txd, led9, led10} !== 3'b100) begin
      errors++;
      $display("FAIL async_reset: txd,led9,led10=%b want 100", {uart0_txd, led9, led10});
    end
    repeat (3) @(negedge clk);
    mcu_rst = 1'b1;
    fork
      begin
        wait_txd_low(8, seen);
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL restart_start: seen=%b want 1", seen); end
        for (int i = 0; i < 8; i++) begin
          uart_recv(b, ok);
          checks++;
          if ({ok, b} !== {1'b1, banner_exp[i]}) begin
            errors++;
            $display("FAIL restart_byte %0d: got %h framing_ok=%b want %h", i, b, ok, banner_exp[i]);
          end
        end
        uart_recv(b, ok);
        checks++;
        if ({ok, b} !== {1'b1, 8'h11}) begin errors++; $display("FAIL overrun_kept: got %h framing_ok=%b want 11", b, ok); end
        watch_idle(200, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL overrun_dropped: second byte was echoed, want dropped"); end
      end
      begin
        repeat (4) @(negedge clk);
        uart_send(8'h11, 1'b1);
        checks++;
        if ({led9, led10} !== 2'b10) begin errors++; $display("FAIL buffered_leds: led9,led10=%b want 10", {led9, led10}); end
        uart_send(8'h22, 1'b1);
        checks++;
        if ({led9, led10} !== 2'b01) begin errors++; $display("FAIL overrun_leds: led9,led10=%b want 01", {led9, led10}); end
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_banner();
    test_heartbeat();
    test_echo();
    test_ferr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
